// File: rtl/sat_addsub_pkg.sv
// Shared types and helpers for the sequential saturating add/subtract unit.
package sat_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Most positive two's-complement value of width w (w <= 64), zero-extended.
  function automatic logic [63:0] signed_max(input int unsigned w);
    logic [63:0] r;
    r = '0;
    for (int unsigned i = 0; i < w - 1; i++) r[i] = 1'b1;
    return r;
  endfunction

  // Most negative two's-complement value of width w (w <= 64), zero-extended.
  function automatic logic [63:0] signed_min(input int unsigned w);
    logic [63:0] r;
    r = '0;
    r[w - 1] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/sat_addsub_seq_cla_chunk.sv
// Combinational CHUNK-bit carry-lookahead adder group.
module cla_chunk #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  logic [CHUNK-1:0] g;
  logic [CHUNK-1:0] p;
  logic [CHUNK:0]   c;
  logic             cc;
  logic             pr;

  // Each carry is the flattened sum-of-products g[i] | p[i]g[i-1] | ... | p[i..0]cin.
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    cc   = 1'b0;
    pr   = 1'b0;
    c[0] = cin;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      cc = g[i];
      pr = p[i];
      for (int unsigned k = 0; k < i; k++) begin
        cc = cc | (pr & g[i-1-k]);
        pr = pr & p[i-1-k];
      end
      c[i+1] = cc | (pr & cin);
    end
  end

  assign sum  = p ^ c[CHUNK-1:0];
  assign cout = c[CHUNK];

endmodule

// File: rtl/sat_addsub_seq.sv
// Multi-cycle signed add/subtract, one CLA chunk per cycle, valid/ready on both sides.
// Define SAT_ADDSUB_SATURATE_EN to clamp overflowing results to signed max/min.
module sat_addsub_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovfl
);
  import sat_addsub_pkg::*;

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic             last;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] sum_nxt;
  logic             ovfl_nxt;
  logic             carry;
  logic [IDXW-1:0]  idx;

  logic [CHUNK-1:0] chunk_a;
  logic [CHUNK-1:0] chunk_b;
  logic [CHUNK-1:0] chunk_sum;
  logic             chunk_cout;

  assign last = (idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (accept) state_nxt = BUSY;
      end
      BUSY: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        accept    = in_valid & out_ready;
        if (out_ready) state_nxt = accept ? BUSY : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign chunk_a = a_q[idx*CHUNK +: CHUNK];
  assign chunk_b = b_q[idx*CHUNK +: CHUNK];

  cla_chunk #(.CHUNK(CHUNK)) u_cla (
    .a    (chunk_a),
    .b    (chunk_b),
    .cin  (carry),
    .sum  (chunk_sum),
    .cout (chunk_cout)
  );

  // On the last chunk, raw is the full result with the current chunk merged in.
  always_comb begin
    raw = res_q;
    raw[idx*CHUNK +: CHUNK] = chunk_sum;
    ovfl_nxt = (a_q[WIDTH-1] == b_q[WIDTH-1]) & (raw[WIDTH-1] != a_q[WIDTH-1]);
  end

`ifdef SAT_ADDSUB_SATURATE_EN
  localparam logic [WIDTH-1:0] SMAX = WIDTH'(signed_max(WIDTH));
  localparam logic [WIDTH-1:0] SMIN = WIDTH'(signed_min(WIDTH));

  always_comb begin
    sum_nxt = raw;
    if (ovfl_nxt) sum_nxt = a_q[WIDTH-1] ? SMIN : SMAX;
  end
`else
  assign sum_nxt = raw;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovfl  <= 1'b0;
    end else if (accept) begin
      a_q   <= a;
      b_q   <= sub ? ~b : b;
      carry <= sub;
      idx   <= '0;
    end else if (state == BUSY) begin
      res_q <= raw;
      carry <= chunk_cout;
      idx   <= idx + IDXW'(1);
      if (last) begin
        sum  <= sum_nxt;
        cout <= chunk_cout;
        ovfl <= ovfl_nxt;
      end
    end
  end

endmodule

// File: tb/tb_sat_addsub_seq.sv
// Scoreboard bench for sat_addsub_seq against an integer-arithmetic reference model.
module tb_sat_addsub_seq;

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        o;
    int unsigned acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] sum;
  logic        cout;
  logic        ovfl;

  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;
  exp_t        q[$];
  bit          seen = 1'b0;
  logic [15:0] held;

  sat_addsub_seq #(.WIDTH(16), .CHUNK(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovfl      (ovfl)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] ta, input logic [15:0] tb,
                                 input logic ts, input int unsigned acc);
    exp_t e;
    int ai, bi, r;
    int unsigned ua, ub;
    ai = $signed(ta);
    bi = $signed(tb);
    ua = ta;
    ub = tb;
    r  = ts ? ai - bi : ai + bi;
    e.o = (r > 32767) || (r < -32768);
    e.c = ts ? (ua >= ub) : (ua + ub > 65535);
    e.s = 16'(r);
`ifdef SAT_ADDSUB_SATURATE_EN
    if (r > 32767)  e.s = 16'h7FFF;
    if (r < -32768) e.s = 16'h8000;
`endif
    e.acc = acc;
    return e;
  endfunction

  // Monitor: samples 2 ns before each rising edge.
  always @(negedge clk) begin
    exp_t e;
    #3;
    if (!rst_n) begin
      seen = 1'b0;
    end else if (out_valid) begin
      chk("in_ready_in_done", in_ready, out_ready);
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got out_valid=1 sum=%h expected no result", sum);
      end else begin
        if (!seen) begin
          seen = 1'b1;
          held = sum;
          chk("latency", cyc - q[0].acc, 4);
        end else begin
          chk("hold_stable", sum, held);
        end
        if (out_ready) begin
          e = q.pop_front();
          chk("sum", sum, e.s);
          chk("cout", cout, e.c);
          chk("ovfl", ovfl, e.o);
          seen = 1'b0;
        end
      end
    end
  end

  task automatic issue(input logic [15:0] ta, input logic [15:0] tb, input logic ts,
                       input bit rnd, output int unsigned tries);
    bit done;
    done  = 1'b0;
    tries = 0;
    while (!done && tries < 100) begin
      @(negedge clk);
      a         = ta;
      b         = tb;
      sub       = ts;
      in_valid  = 1'b1;
      out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      #2;
      tries++;
      if (in_ready) begin
        q.push_back(model(ta, tb, ts, cyc + 1));
        done = 1'b1;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no accept expected accept within 100 cycles");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      n++;
    end
    @(negedge clk);
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin
    int unsigned t;
    int unsigned n;
    logic [15:0] ra, rb;

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #3;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_sum", sum, 0);
    chk("reset_cout", cout, 0);
    chk("reset_ovfl", ovfl, 0);

    issue(16'h1234, 16'h0FF0, 1'b0, 1'b0, t);
    issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, t);
    issue(16'h8000, 16'h0001, 1'b1, 1'b0, t);
    issue(16'h0005, 16'h0005, 1'b1, 1'b0, t);
    drain();

    // Backpressure: hold result for 3 cycles, then consume and accept on one edge.
    issue(16'h4000, 16'h4000, 1'b0, 1'b0, t);
    out_ready = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      #3;
      n++;
    end
    chk("bp_result_seen", out_valid, 1);
    repeat (3) begin
      @(negedge clk);
      #3;
      chk("bp_in_ready_low", in_ready, 0);
      chk("bp_out_valid_held", out_valid, 1);
    end
    issue(16'h0123, 16'h0321, 1'b0, 1'b0, t);
    chk("bp_same_edge_accept", t, 1);
    drain();

    // Reset in the middle of BUSY abandons the operation.
    issue(16'h1111, 16'h2222, 1'b0, 1'b0, t);
    @(negedge clk);
    rst_n = 1'b0;
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #3;
    chk("midreset_out_valid", out_valid, 0);
    chk("midreset_in_ready", in_ready, 1);
    repeat (6) begin
      @(negedge clk);
      #3;
      chk("midreset_no_result", out_valid, 0);
    end
    issue(16'h0001, 16'h0001, 1'b0, 1'b0, t);
    drain();

    for (int unsigned i = 0; i < 60; i++) begin
      case ($urandom_range(0, 5))
        0:       ra = 16'h7FFF;
        1:       ra = 16'h8000;
        default: ra = 16'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0:       rb = 16'h7FFF;
        1:       rb = 16'h8000;
        default: rb = 16'($urandom);
      endcase
      issue(ra, rb, 1'($urandom_range(0, 1)), 1'b1, t);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
